pipe_muldiv_unit: RTL
=====================

// Module: pipe_muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit with architectural HI/LO registers.
//  Sits beside the ALU in the EX stage of the pipelined datapath.
//  - executes MULT/MULTU/DIV/DIVU over multiple cycles; serves MFHI/MFLO/MTHI/MTLO
//  - raises a stall request so the hazard unit freezes PC, IF/ID and ID/EX while busy
// PARAMETERS
//  XLEN   32             operand width; HI/LO are XLEN each; product is 2*XLEN
//  CNT_W  $clog2(XLEN)+1 iteration counter width (derived, not overridden)
// PORTS
//  clk         in   1     rising-edge clock, single clock domain
//  rst         in   1     synchronous, active-high reset
//  issue       in   1     op valid this cycle (ID/EX slot holds a muldiv-class instr)
//  op          in   3     operation code (see package)
//  src_a       in   XLEN  rs operand (forwarded value)
//  src_b       in   XLEN  rt operand (forwarded value)
//  flush       in   1     abort in-flight op, drop issue this cycle
//  stall_req   out  1     hazard unit must hold pipeline this cycle
//  busy        out  1     iterative op in flight
//  done        out  1     one-cycle pulse: HI/LO just updated by MULT/DIV
//  div0        out  1     one-cycle pulse with done: divide by zero occurred
//  rd_data     out  XLEN  MFHI/MFLO result to EX/MEM result mux
//  hi_out      out  XLEN  HI register
//  lo_out      out  XLEN  LO register
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, busy=done=div0=0, counter=0; rst wins over all inputs.
//  Op codes: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
//  FSM IDLE -> RUN -> FIX -> IDLE.
//  - IDLE: issue & MULT/DIV-class & !flush -> latch operand magnitudes/sign flags,
//    counter=0, go RUN.
//  - RUN: one bit per cycle (shift-add multiply / restoring divide), XLEN cycles;
//    counter==XLEN-1 -> FIX.
//  - FIX: apply sign correction, write HI/LO, go IDLE; done (and div0) high in the following cycle.
//  Latency: start sampled at edge k; HI/LO valid and done=1 after edge k+XLEN+1.
//  - busy = (state!=IDLE), registered; high for XLEN+1 cycles.
//  stall_req = issue & busy (combinational). The op is ignored and must be re-presented.
//  Stalled MF* therefore never returns stale HI/LO.
//  MFHI/MFLO in IDLE: rd_data = HI/LO combinationally, same cycle, 0 latency.
//  - rd_data = 0 when not an MF* issue.
//  MTHI/MTLO in IDLE: HI/LO <= src_a at next edge; no done pulse.
//  Arithmetic:
//  - MULT: signed 2*XLEN product, {HI,LO}; MULTU unsigned.
//  - DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
//  - DIVU: unsigned.
//  Boundaries:
//  - divide by zero: no iteration skipped (same latency); HI=src_a, LO=all-ones, div0=1.
//  - signed overflow (MIN / -1): LO=MIN, HI=0, div0=0.
//  - flush while RUN/FIX: next edge -> IDLE, HI/LO untouched, no done.
//  - flush & issue same cycle: issue dropped; MTHI/MTLO also dropped.
//  - issue while busy (any op): stalled, no state change.
//  - rst mid-operation: immediate return to reset values.
// STRUCTURE
//  Shared package pipe_muldiv_pkg: op code localparams, FSM state encoding (IDLE/RUN/FIX).
//  - also holds the helper predicate is_iter_op(op).
//  One sub-module: muldiv_iter_core.
//  - holds the XLEN-step shift-add/restore datapath plus accumulator registers.
//  - start/step/last handshake driven by the FSM in this module.
//  Top module owns FSM, sign fixup, HI/LO, MF/MT muxing and stall logic.
// TESTING
//  MULT -3 x 7 (XLEN=32) -> after 34 cycles HI=FFFFFFFF, LO=FFFFFFEB, done 1 cycle, busy 33 cycles.
//  DIV -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1.
//  - DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0, div0=0.
//  DIVU 5 / 0 -> HI=5, LO=FFFFFFFF, div0=1 coincident with done.
//  MFLO issued 3 cycles after MULTU FFFFFFFF x 2 -> stall_req high until IDLE.
//  - then rd_data=FFFFFFFE, HI=1.
//  - MTHI 1234 in IDLE -> hi_out=1234 next cycle.
//  DIV started, flush at cycle 10 -> IDLE next edge, HI/LO unchanged, no done.
//  - rst asserted at cycle 5 of a MULT -> HI=LO=0, busy=0.

Source files
------------

// File: rtl/pipe_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op codes    : 3-bit operation encoding presented on the op port
//   state_t     : control FSM encoding (IDLE/RUN/FIX)
//   is_iter_op  : true for the multi-cycle MULT/MULTU/DIV/DIVU class
package pipe_muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MFHI  = 3'b100;
   localparam logic [2:0] OP_MFLO  = 3'b101;
   localparam logic [2:0] OP_MTHI  = 3'b110;
   localparam logic [2:0] OP_MTLO  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   function automatic logic is_iter_op(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/pipe_muldiv_unit_core.sv
// muldiv_iter_core: one-bit-per-step unsigned datapath.
//   clk, rst         : clock, synchronous active-high reset
//   start            : load magnitudes and operation kind
//   step             : perform one shift-add (multiply) or restoring-divide step
//   is_div, a_mag, b_mag : operation kind and unsigned operands, sampled on start
//   res_hi, res_lo   : multiply -> {product high, product low}
//                      divide   -> {remainder, quotient}
module muldiv_iter_core
   import pipe_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic            is_div,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic            div_q, div_d;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   sum;

   always_comb begin
      acc_d  = acc_q;
      lo_d   = lo_q;
      b_d    = b_q;
      div_d  = div_q;
      rem_sh = {acc_q, lo_q[XLEN-1]};
      sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      if (start) begin
         acc_d = '0;
         lo_d  = a_mag;
         b_d   = b_mag;
         div_d = is_div;
      end else if (step) begin
         if (div_q) begin
            // Restoring divide: a zero divisor always "fits", giving an
            // all-ones quotient and the dividend as remainder.
            if (rem_sh >= {1'b0, b_q}) begin
               acc_d = rem_sh[XLEN-1:0] - b_q;
               lo_d  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               acc_d = rem_sh[XLEN-1:0];
               lo_d  = {lo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            // Shift-add multiply: multiplier drains out of lo_q's LSB while
            // product bits shift in from the top.
            acc_d = sum[XLEN:1];
            lo_d  = {sum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
         div_q <= div_d;
      end
   end

   assign res_hi = acc_q;
   assign res_lo = lo_q;

endmodule

// File: rtl/pipe_muldiv_unit.sv
// pipe_muldiv_unit: iterative MULT/DIV unit with architectural HI/LO.
//   clk, rst        : clock, synchronous active-high reset
//   issue, op       : muldiv-class instruction valid in ID/EX and its op code
//   src_a, src_b    : forwarded rs/rt operands
//   flush           : abort in-flight op and drop this cycle's issue
//   stall_req       : freeze the pipeline (issue while busy)
//   busy            : iterative op in flight
//   done, div0      : one-cycle pulses after HI/LO update / divide by zero
//   rd_data         : MFHI/MFLO result
//   hi_out, lo_out  : HI and LO registers
//
// state   | meaning
// IDLE    | accepts MF/MT and starts MULT/DIV
// RUN     | XLEN datapath steps in muldiv_iter_core
// FIX     | sign correction, HI/LO write, done pulse next cycle
module pipe_muldiv_unit
   import pipe_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic            div0,
   output logic [XLEN-1:0] rd_data,
   output logic [XLEN-1:0] hi_out,
   output logic [XLEN-1:0] lo_out
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, a_raw_q, a_raw_d;
   logic              done_q, done_d, div0_q, div0_d;
   logic              is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
   logic              dz_q, dz_d;
   logic              core_start, core_step, signed_op;
   logic [XLEN-1:0]   a_mag, b_mag, core_hi, core_lo;
   logic [2*XLEN-1:0] prod;

   assign signed_op = ~op[0];
   assign a_mag     = (signed_op && src_a[XLEN-1]) ? (~src_a + 1'b1) : src_a;
   assign b_mag     = (signed_op && src_b[XLEN-1]) ? (~src_b + 1'b1) : src_b;
   assign prod      = {core_hi, core_lo};

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (core_start),
      .step   (core_step),
      .is_div (op[1]),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .res_hi (core_hi),
      .res_lo (core_lo)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      a_raw_d    = a_raw_q;
      is_div_d   = is_div_q;
      neg_q_d    = neg_q_q;
      neg_r_d    = neg_r_q;
      dz_d       = dz_q;
      done_d     = 1'b0;
      div0_d     = 1'b0;
      core_start = 1'b0;
      core_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (issue && !flush) begin
               if (is_iter_op(op)) begin
                  state_d    = ST_RUN;
                  cnt_d      = '0;
                  core_start = 1'b1;
                  is_div_d   = op[1];
                  neg_q_d    = signed_op & (src_a[XLEN-1] ^ src_b[XLEN-1]);
                  neg_r_d    = signed_op & src_a[XLEN-1];
                  dz_d       = (src_b == '0);
                  a_raw_d    = src_a;
               end else if (op == OP_MTHI) begin
                  hi_d = src_a;
               end else if (op == OP_MTLO) begin
                  lo_d = src_a;
               end
            end
         end
         ST_RUN: begin
            core_step = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
               div0_d = dz_q;
               if (dz_q) begin
                  // Signed divide by zero reports the raw dividend, not
                  // a sign-corrected magnitude.
                  hi_d = a_raw_q;
                  lo_d = '1;
               end else begin
                  lo_d = neg_q_q ? (~core_lo + 1'b1) : core_lo;
                  hi_d = neg_r_q ? (~core_hi + 1'b1) : core_hi;
               end
            end else begin
               {hi_d, lo_d} = neg_q_q ? (~prod + 1'b1) : prod;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush && state_q != ST_IDLE) begin
         state_d   = ST_IDLE;
         core_step = 1'b0;
         hi_d      = hi_q;
         lo_d      = lo_q;
         done_d    = 1'b0;
         div0_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         a_raw_q  <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         a_raw_q  <= a_raw_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
         div0_q   <= div0_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign stall_req = issue & busy;
   assign done      = done_q;
   assign div0      = div0_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

   // MF* reads only complete in IDLE; a stalled read is re-presented later.
   always_comb begin
      rd_data = '0;
      if (issue && !busy && !flush) begin
         if (op == OP_MFHI)      rd_data = hi_q;
         else if (op == OP_MFLO) rd_data = lo_q;
      end
   end

endmodule
